// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the async_fifo block.
// Optional feature macro used across the block: ASYNC_FIFO_ERR_FLAGS_EN.
package async_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 8;
    localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);

    // Pointer of the default configuration: array address plus one wrap bit.
    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

endpackage : async_fifo_pkg

// File: rtl/async_fifo_if.sv
// Producer/consumer bus of async_fifo.
// ASYNC_FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow flags.
interface async_fifo_if
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;

    modport master (output w_en, r_en, data_in,
                    input  full, empty, data_out, overflow, underflow);
    modport slave  (input  w_en, r_en, data_in,
                    output full, empty, data_out, overflow, underflow);
`else
    modport master (output w_en, r_en, data_in,
                    input  full, empty, data_out);
    modport slave  (input  w_en, r_en, data_in,
                    output full, empty, data_out);
`endif

endinterface : async_fifo_if

// File: rtl/async_fifo_mem.sv
// fifo_mem: simple dual-port RAM, synchronous write port and a registered
// read port whose output register clears on reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port: store the word at the write address.
    // NOTE: the array has no reset; pointers decide which words are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: capture the head word on an accepted read, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : fifo_mem

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with wrap-bit pointers and registered read data.
// Define ASYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst_n,
    async_fifo_if.slave bus
);

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic                full_w, empty_w;
    logic                wr_accept, rd_accept;

    // Flags come straight from the registered pointers, so a reset clears them at once.
    assign empty_w = (wptr_q == rptr_q);
    assign full_w  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                     (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

    // Each request is qualified against the flags as they stood before the edge.
    assign wr_accept = bus.w_en & ~full_w;
    assign rd_accept = bus.r_en & ~empty_w;

    // Next pointer values: advance by one on each accepted request.
    // NOTE: every output of a combinational block gets a default first, otherwise an unassigned path infers a latch.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_accept) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_accept) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_accept),
        .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (bus.data_in),
        .re_i    (rd_accept),
        .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (bus.data_out)
    );

    assign bus.full  = full_w;
    assign bus.empty = empty_w;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags: set on any rejected request, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (bus.w_en & full_w);
            underflow_q <= underflow_q | (bus.r_en & empty_w);
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule : async_fifo

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo against a queue-based reference model.
// Compile with ASYNC_FIFO_ERR_FLAGS_EN to also check overflow/underflow.
module tb_async_fifo;
    import async_fifo_pkg::*;

    localparam int DW = DATA_WIDTH_DEF;
    localparam int DP = DEPTH_DEF;

    logic clk;
    logic rst_n;

    async_fifo_if #(.DATA_WIDTH(DW)) bus ();

    async_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, expected read register, sticky errors.
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] dout_exp;
    logic          ovf_exp;
    logic          unf_exp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string phase);
        check({phase, ".empty"},    32'(bus.empty),    32'(model_q.size() == 0));
        check({phase, ".full"},     32'(bus.full),     32'(model_q.size() == DP));
        check({phase, ".data_out"}, 32'(bus.data_out), 32'(dout_exp));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check({phase, ".overflow"},  32'(bus.overflow),  32'(ovf_exp));
        check({phase, ".underflow"}, 32'(bus.underflow), 32'(unf_exp));
`endif
    endtask

    // One clock: apply requests, let the edge happen, advance the model, sample 1ns later.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input string phase);
        int  occ;
        bit  wr_ok, rd_ok;
        bus.w_en    = w;
        bus.r_en    = r;
        bus.data_in = d;
        @(posedge clk);
        occ   = model_q.size();
        wr_ok = w && (occ < DP);
        rd_ok = r && (occ > 0);
        if (w && occ == DP) ovf_exp = 1'b1;
        if (r && occ == 0)  unf_exp = 1'b1;
        if (rd_ok) dout_exp = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        #1;
        check_outputs(phase);
    endtask

    task automatic model_reset();
        model_q.delete();
        dout_exp = '0;
        ovf_exp  = 1'b0;
        unf_exp  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] b;
        int            wp, rp;

        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        model_reset();

        // Reset held for 4 cycles.
        rst_n = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check_outputs("reset");
        end
        rst_n = 1'b1;

        // Fill past capacity: writes 9..20 are dropped.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, DW'($urandom), "fill");

        // Drain past empty: data_out holds the last word once empty.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0, "drain");

        // Concurrent read and write at constant occupancy.
        cycle(1'b1, 1'b0, 8'h11, "conc_pre");
        cycle(1'b1, 1'b0, 8'h22, "conc_pre");
        cycle(1'b1, 1'b0, 8'h33, "conc_pre");
        for (int i = 0; i < 5; i++) begin
            b = 8'h44 + 8'(i * 8'h11);
            cycle(1'b1, 1'b1, b, "conc");
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0, "conc_drain");

        // Three full passes across pointer rollover.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < DP; i++) cycle(1'b1, 1'b0, DW'($urandom), "wrap_fill");
            for (int i = 0; i < DP; i++) cycle(1'b0, 1'b1, '0, "wrap_drain");
        end

        // Randomised traffic with varying write/read bias.
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: begin wp = 80; rp = 30; end
                1: begin wp = 30; rp = 80; end
                2: begin wp = 60; rp = 60; end
                default: begin wp = 95; rp = 95; end
            endcase
            for (int i = 0; i < 100; i++) begin
                cycle(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp),
                      DW'($urandom), "random");
            end
        end

        // Reset in the middle of operation with 5 words stored.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0, "mid_flush");
        for (int i = 0; i < 5; i++)  cycle(1'b1, 1'b0, DW'($urandom), "mid_fill");
        check("mid.pre_empty", 32'(bus.empty), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset");
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'hA5, "post_reset");
        cycle(1'b0, 1'b1, '0,    "post_reset");
        check("post_reset.word", 32'(bus.data_out), 32'h0000_00A5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_async_fifo

// File: doc/async_fifo.md
# async_fifo

Single-clock, parameterised first-in-first-out buffer with asynchronous active-low reset. It decouples a byte-stream producer from a consumer that runs in the same clock domain but issues reads at a different rate. It sits between a data source driving `w_en`/`data_in` and a sink driving `r_en`/`data_out`. `full` and `empty` flags provide back-pressure.

## Interface
- `DATA_WIDTH`, default 8: width of each stored word.
- `DEPTH`, default 8: number of entries; must be a power of two, minimum 2.
- `ADDR_WIDTH`, default $clog2(DEPTH): derived; not to be overridden.
- `clk  input  1`: the single clock; all state updates on its rising edge.
- `rst_n  input  1`: reset; asynchronous, active-low; clears pointers and output register.
- `w_en  input  1`: write request; `data_in` is captured on the rising edge when `w_en=1` and `full=0`.
- `r_en  input  1`: read request; the head word is popped on the rising edge when `r_en=1` and `empty=0`.
- `data_in  input  DATA_WIDTH`: write data.
- `full  output  1`: high when DEPTH words are stored.
- `empty  output  1`: high when 0 words are stored.
- `data_out  output  DATA_WIDTH`: registered read data.

## Operation
- **Storage:** DEPTH×DATA_WIDTH array. Write pointer `wptr` and read pointer `rptr` are each ADDR_WIDTH+1 bits. The MSB is the wrap bit; the low bits address the array.
- **Write:** accepted when `w_en & ~full`. Stores `mem[wptr[ADDR_WIDTH-1:0]] <= data_in` and increments `wptr` modulo 2^(ADDR_WIDTH+1).
- **Read:** accepted when `r_en & ~empty`. Registers `data_out <= mem[rptr[ADDR_WIDTH-1:0]]` and increments `rptr`.
- **Flags:** combinational from the registered pointers.
  - `empty = (wptr == rptr)`.
  - `full = (wptr[MSB] != rptr[MSB]) && (low bits equal)`.
- **Rejected requests:** a write while full is dropped; memory and `wptr` are unchanged. A read while empty is dropped; `data_out` holds its previous value.
- **Simultaneous `w_en` and `r_en`:**
  - Each request is qualified independently against the flag value before the edge.
  - When not full and not empty, both are accepted and the occupancy is unchanged.
  - When full, only the read is accepted. When empty, only the write is accepted.
- **Wrap-around:** pointers roll over naturally. Occupancy is always `wptr - rptr` (mod 2^(ADDR_WIDTH+1)) and never exceeds DEPTH.
- **Reset values:** `wptr=0`, `rptr=0`, `data_out=0`, `empty=1`, `full=0`. Memory contents are not reset.
- **Reset mid-operation:** all stored words are discarded immediately. `empty` asserts asynchronously with the reset assertion.

## Timing
- Write-to-flag latency: `empty` deasserts after the first accepted write edge. `full` asserts after the edge of the DEPTH-th net write.
- Read latency: `data_out` is valid one edge after the accepted read request. It is sampled in the cycle following that edge.
- Read-to-flag latency: `full` deasserts after the edge of the first read from full. `empty` asserts after the edge that pops the last word.
- Throughput: one write and one read per clock.
- Reset release must be synchronous to `clk` at the system level; the block adds no synchroniser.

## Configuration
- `ASYNC_FIFO_ERR_FLAGS_EN` defined:
  - Adds outputs `overflow` and `underflow` (1 bit each), reset to 0.
  - `overflow` sets on any edge with `w_en & full`. `underflow` sets on any edge with `r_en & empty`.
  - Both are sticky until `rst_n` is asserted.
- Not defined: the ports and the logic are absent; the remaining behaviour is identical.

## Structure
- Package `async_fifo_pkg`: `DATA_WIDTH_DEF=8` and `DEPTH_DEF=8` constants, plus a `ptr_t` typedef sized for the wrap bit.
- One sub-module: `fifo_mem`, a simple dual-port RAM with one synchronous write port and one synchronous registered read port.
- Pointers, flags and error logic stay in `async_fifo`.

## Test plan
- Reset: hold `rst_n=0` for 4 cycles → `empty=1`, `full=0`, `data_out=0`.
- Fill/overflow: write 20 pseudo-random bytes with `w_en=1`, `r_en=0`.
  - `full=1` after the 8th write.
  - Writes 9–20 are dropped; with the macro, `overflow=1`.
- Drain: then `r_en=1` for 10 cycles.
  - `data_out` shows the first 8 written bytes in order, each one cycle after its read.
  - `empty=1` after the 8th read; `data_out` then holds byte 8.
  - With the macro, `underflow=1`.
- Concurrent: after 3 writes (0x11, 0x22, 0x33), assert `w_en` and `r_en` together for 5 cycles writing 0x44–0x88.
  - Occupancy stays 3; `data_out` reads 0x11, 0x22, 0x33, 0x44, 0x55.
- Wrap: perform 3 complete fill/drain passes (24 words) → data ordering is preserved and flags are correct across pointer rollover.
- Reset mid-operation: with 5 words stored, pulse `rst_n` low between edges → `empty=1` immediately; a subsequent write/read returns the new word.
